// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: round-robin icache/dcache line arbiter driving BEAT_W x N_BEATS memory bursts
module cacheline_arbiter #(
  parameter int BEAT_W  = 64,
  parameter int N_BEATS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 i_address,
  input  logic                        i_read,
  output logic [BEAT_W*N_BEATS-1:0]   i_rdata,
  output logic                        i_resp,
  input  logic [31:0]                 d_address,
  input  logic                        d_read,
  input  logic                        d_write,
  input  logic [BEAT_W*N_BEATS-1:0]   d_wdata,
  output logic [BEAT_W*N_BEATS-1:0]   d_rdata,
  output logic                        d_resp,
  output logic [31:0]                 mem_address,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [BEAT_W-1:0]           mem_wdata,
  input  logic [BEAT_W-1:0]           mem_rdata,
  input  logic                        mem_resp
);
  localparam int LINE_W = BEAT_W * N_BEATS;
  localparam int KW = $clog2(N_BEATS);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESPOND} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic last_q, last_d, cli_q, cli_d;
  logic [31:0] addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic ireq, dreq, gnt_d, busy, last_beat;
  always_comb begin
    ireq = i_read;
    dreq = d_read | d_write;
    gnt_d = dreq & (~ireq | ~last_q);
    busy = state_q == READ || state_q == WRITE;
    last_beat = busy && mem_resp && k_q == KW'(N_BEATS - 1);
    state_d = state_q;
    k_d = k_q;
    last_d = last_q;
    cli_d = cli_q;
    addr_d = addr_q;
    line_d = line_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: if (ireq | dreq) begin
        cli_d = gnt_d;
        last_d = gnt_d;
        addr_d = (gnt_d ? d_address : i_address) & ~32'(LINE_W / 8 - 1);
        line_d = (gnt_d & d_write) ? d_wdata : line_q;
        state_d = (gnt_d & d_write) ? WRITE : READ;
      end
      READ, WRITE: if (mem_resp) begin
        if (state_q == READ) line_d[BEAT_W*k_q +: BEAT_W] = mem_rdata;
        k_d = last_beat ? '0 : k_q + 1'b1;
        state_d = last_beat ? RESPOND : state_q;
      end
      default: state_d = IDLE;
    endcase
    i_rdata_d = (last_beat && !cli_q) ? line_d : i_rdata_q;
    d_rdata_d = (last_beat && cli_q) ? line_d : d_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      last_q <= 1'b0;
      cli_q <= 1'b0;
      addr_q <= '0;
      line_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      last_q <= last_d;
      cli_q <= cli_d;
      addr_q <= addr_d;
      line_q <= line_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign mem_read = state_q == READ;
  assign mem_write = state_q == WRITE;
  assign mem_address = addr_q;
  assign mem_wdata = mem_write ? line_q[BEAT_W*k_q +: BEAT_W] : '0;
  assign i_resp = state_q == RESPOND && !cli_q;
  assign d_resp = state_q == RESPOND && cli_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed and randomized checks of cacheline_arbiter against a memory model
module tb_cacheline_arbiter;
  logic clk = 1'b0, rst;
  logic [31:0] i_address, d_address, mem_address;
  logic i_read, i_resp, d_read, d_write, d_resp, mem_read, mem_write, mem_resp;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic [63:0] mem_wdata, mem_rdata;
  cacheline_arbiter dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, pct = 100, op_cycles = 0;
  bit scripted = 0, idle_poke = 0, last_d = 0;
  logic [31:0] mask = 32'h0;
  logic [255:0] mem_arr [logic [31:0]];
  logic [255:0] ref_mem [logic [31:0]];
  logic [31:0] bursts [$];
  logic [31:0] pool [4] = '{32'h0000_0100, 32'h0000_2000, 32'h8000_0040, 32'hffff_ffe0};
  function automatic logic [255:0] pat(logic [31:0] a);
    return {a, 32'hd3, a, 32'hc2, a, 32'hb1, a, 32'ha0};
  endfunction
  function automatic logic [255:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    int rb, cyc;
    logic [255:0] l, wl;
    bit go;
    rb = 0;
    cyc = 0;
    wl = '0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata = {$urandom, $urandom};
      if (rst) begin
        rb = 0;
        cyc = 0;
        mem_resp = 1'b0;
      end else if (mem_read || mem_write) begin
        cyc++;
        if (cyc == 1) bursts.push_back(mem_address);
        go = scripted ? (cyc < 32 && mask[cyc] == 1'b1) : ($urandom_range(99) < pct);
        mem_resp = go;
        if (go) begin
          l = mem_arr.exists(mem_address) ? mem_arr[mem_address] : pat(mem_address);
          if (mem_read) mem_rdata = l[64*rb +: 64];
          else wl[64*rb +: 64] = mem_wdata;
          if (mem_write && rb == 3) mem_arr[mem_address] = wl;
          rb = (rb + 1) % 4;
        end
      end else begin
        mem_resp = idle_poke;
        cyc = 0;
      end
    end
  end
  task automatic reset_dut();
    rst = 1'b1;
    i_read = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    last_d = 1'b0;
    bursts.delete();
  endtask
  task automatic serve(string tag);
    bit exp_d, wr;
    int n, nb;
    logic [31:0] a, got;
    logic [255:0] e;
    exp_d = (d_read || d_write) && (!i_read || !last_d);
    wr = exp_d && d_write;
    a = (exp_d ? d_address : i_address) & ~32'h1f;
    n = 0;
    nb = 0;
    op_cycles = 0;
    @(negedge clk);
    #1;
    chk({tag, " no resp after grant"}, {i_resp, d_resp}, 0);
    while (!(i_resp || d_resp) && n < 400) begin
      if (mem_read || mem_write) op_cycles++;
      if (wr && mem_write) begin
        chk({tag, " wdata beat"}, mem_wdata, d_wdata[64*(nb%4) +: 64]);
        if (mem_resp) nb++;
      end
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, " resp within budget"}, n < 400, 1);
    chk({tag, " i_resp"}, i_resp, !exp_d);
    chk({tag, " d_resp"}, d_resp, exp_d);
    got = bursts.size() != 0 ? bursts.pop_front() : 32'hxxxx_xxxx;
    chk({tag, " burst address"}, got, a);
    if (wr) ref_mem[a] = d_wdata;
    else begin
      e = ref_mem.exists(a) ? ref_mem[a] : pat(a);
      chk({tag, " rdata"}, exp_d ? d_rdata : i_rdata, e);
    end
    last_d = exp_d;
    if (exp_d) begin
      d_read = 1'b0;
      d_write = 1'b0;
    end else i_read = 1'b0;
  endtask
  initial begin
    int n, nb;
    logic [255:0] line4;
    rst = 1'b1;
    i_address = '0;
    d_address = '0;
    i_read = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
    d_wdata = '0;
    reset_dut();
    chk("reset mem_read", mem_read, 0);
    chk("reset mem_write", mem_write, 0);
    chk("reset mem_address", mem_address, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset i_resp", i_resp, 0);
    chk("reset d_resp", d_resp, 0);
    chk("reset i_rdata", i_rdata, 0);
    chk("reset d_rdata", d_rdata, 0);
    line4 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    mem_arr[32'h1220] = line4;
    ref_mem[32'h1220] = line4;
    i_address = 32'h0000_1234;
    i_read = 1'b1;
    pct = 100;
    chk("icache read idle cycle mem_read", mem_read, 0);
    serve("icache read");
    chk("icache read mem_read cycles", op_cycles, 4);
    chk("icache read line", i_rdata, line4);
    d_address = 32'h8000_0040;
    d_wdata = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_0011223344abcdef;
    d_write = 1'b1;
    scripted = 1'b1;
    mask = 32'h9a;
    serve("dcache write");
    scripted = 1'b0;
    chk("dcache write mem_write cycles", op_cycles, 7);
    reset_dut();
    i_address = 32'h0000_2000;
    d_address = 32'h0000_3000;
    i_read = 1'b1;
    d_read = 1'b1;
    serve("contention dcache first");
    @(negedge clk);
    #1;
    chk("icache idle cycle after d_resp", {mem_read, mem_write}, 0);
    @(negedge clk);
    #1;
    chk("icache granted after d_resp", mem_read, 1);
    chk("icache burst address", mem_address, 32'h0000_2000);
    serve("contention icache second");
    pct = 60;
    d_address = 32'h0000_0100;
    d_wdata = rnd_line();
    d_write = 1'b1;
    i_address = 32'h0000_4000;
    i_read = 1'b1;
    serve("writeback first");
    d_address = 32'h8000_0044;
    d_read = 1'b1;
    serve("pending icache next");
    serve("dcache read of written line");
    pct = 100;
    i_address = 32'h0000_5008;
    i_read = 1'b1;
    n = 0;
    nb = 0;
    while (nb < 2 && n < 50) begin
      @(negedge clk);
      #1;
      if (mem_read && mem_resp) nb++;
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid-burst reset mem_read", mem_read, 0);
    chk("mid-burst reset mem_write", mem_write, 0);
    chk("mid-burst reset resp", {i_resp, d_resp}, 0);
    rst = 1'b0;
    last_d = 1'b0;
    bursts.delete();
    serve("reissued after reset");
    idle_poke = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("idle mem_resp no burst", {mem_read, mem_write}, 0);
      chk("idle mem_resp no resp", {i_resp, d_resp}, 0);
    end
    idle_poke = 1'b0;
    i_address = 32'h0000_1220;
    i_read = 1'b1;
    serve("read after idle mem_resp");
    for (int t = 0; t < 40; t++) begin
      if (!i_read && $urandom_range(9) < 6) begin
        i_address = pool[$urandom_range(3)] | 32'($urandom_range(31));
        i_read = 1'b1;
      end
      if (!d_read && !d_write && $urandom_range(9) < 6) begin
        d_address = pool[$urandom_range(3)] | 32'($urandom_range(31));
        d_wdata = rnd_line();
        if ($urandom_range(1) == 1) d_write = 1'b1;
        else d_read = 1'b1;
      end
      if (!i_read && !d_read && !d_write) begin
        i_address = pool[$urandom_range(3)];
        i_read = 1'b1;
      end
      pct = 30 + $urandom_range(70);
      serve("random");
    end
    for (int t = 0; t < 2; t++) if (i_read || d_read || d_write) serve("drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache, between them and main memory.
- Accepts 256-bit line read/write requests from both caches and arbitrates between them round-robin.
- Converts the granted request into a 4-beat, 64-bit burst on the physical memory interface.
- Returns a single-cycle response with the assembled line to the granted cache.

Parameters:
- BEAT_W, 64: memory data-bus width in bits.
- N_BEATS, 4: beats per line. BEAT_W*N_BEATS must equal 256.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_address  in  32  icache line address; bits [4:0] ignored
- i_read  in  1  icache line read request, level, held until i_resp
- i_rdata  out  256  line returned to icache, valid when i_resp
- i_resp  out  1  icache response, 1-cycle pulse
- d_address  in  32  dcache line address; bits [4:0] ignored
- d_read  in  1  dcache line read request, level
- d_write  in  1  dcache line write request, level; never asserted together with d_read
- d_wdata  in  256  dcache line to write, stable while d_write is held
- d_rdata  out  256  line returned to dcache, valid when d_resp
- d_resp  out  1  dcache response, 1-cycle pulse
- mem_address  out  32  line-aligned burst address
- mem_read  out  1  burst read, held for the whole burst
- mem_write  out  1  burst write, held for the whole burst
- mem_wdata  out  64  current write beat
- mem_rdata  in  64  current read beat, valid when mem_resp
- mem_resp  in  1  per-beat acknowledge; beats may be non-consecutive

Behaviour:
- Reset values: all outputs 0; state=IDLE; beat counter=0; last_grant=ICACHE, so the first contention goes to the dcache.
- States: IDLE, READ, WRITE, RESPOND.
- IDLE:
  - Request sets: ireq=i_read; dreq=d_read|d_write.
  - Only one request: grant it.
  - Both requesting: grant the one not equal to last_grant.
  - On grant: latch client id, address {addr[31:5],5'b0}, op and (for a write) d_wdata into internal registers; update last_grant.
  - Go to READ or WRITE. No memory signal asserts in the IDLE cycle itself; latency from request to mem_read/mem_write is 1 cycle.
- READ:
  - mem_read=1; mem_address=latched address.
  - On each mem_resp: store mem_rdata into line[64*k +: 64], k=beat counter, then increment k.
  - On the resp with k=N_BEATS-1: mem_read drops at the next edge, k resets to 0, go to RESPOND.
- WRITE:
  - mem_write=1; mem_wdata=latched_line[64*k +: 64]; advance k on mem_resp exactly as in READ.
  - After the last beat, go to RESPOND.
- RESPOND:
  - Granted client's resp=1 for exactly 1 cycle; its rdata=assembled line. rdata is don't-care for writes but drives the latched line.
  - Non-granted resp=0. Go to IDLE.
- i_rdata/d_rdata are registered and hold their value until the next RESPOND. Memory-side outputs are registered or derived only from state and registers, never combinationally from client inputs.
- IDLE re-samples requests in the cycle after RESPOND. Clients must have dropped the served request by then. A new request arriving that cycle (e.g. dcache read following its writeback) is legal and granted normally.
- Minimum transaction: 1 (IDLE) + 4 (beats, resp every cycle) + 1 (RESPOND) = 6 cycles.
- A client dropping its request mid-burst is illegal; the block ignores it and completes the burst and response.
- Requests to the non-granted client stay pending, never dropped. Round-robin guarantees each client waits at most one other transaction.
- rst in any state returns the block to IDLE within one edge: mem_read/mem_write deassert, partial line is discarded, no resp issued.
- mem_resp in IDLE or RESPOND is ignored.
- Counter width: $clog2(N_BEATS), wraps to 0 only through an explicit clear.

Test Plan:
- icache read at 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> mem_address=0x0000_1220, mem_read high for 4 cycles, i_resp pulses 1 cycle later with i_rdata={0x44..44,0x33..33,0x22..22,0x11..11}, d_resp stays 0.
- dcache write at 0x8000_0040 with d_wdata=256'h0123...cdef, mem_resp on cycles 1, 3, 4, 7 of the burst -> mem_wdata presents line[63:0] until the first resp, then [127:64], and so on; mem_write drops after the 4th resp; exactly one d_resp.
- i_read and d_read asserted on the same cycle after reset -> dcache served first, then icache; the icache is granted in the IDLE cycle right after d_resp.
- dcache writeback immediately followed by dcache read of a new line while i_read is pending -> order is d_write, i_read, d_read (round-robin), no request lost.
- rst asserted during beat 2 of a read -> next cycle mem_read=0, no resp, state IDLE; a re-issued request completes normally with correct data.
- mem_resp pulsed while IDLE with no requests -> no state change, no resp, counter stays 0.
